// File: rtl/control_logic.sv
// control_logic
// Core control block of an 8259A-compatible interrupt controller. Decodes CPU
// register writes (ICW1, ICW2, OCW1-OCW3) and reads, holds IRR/ISR/IMR,
// resolves fixed priority (IR0 highest) over eight request lines and runs the
// two-pulse INTA vector handshake toward an 8086-style CPU.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   chip_select_n              active-low chip select
//   read_enable_n              active-low read strobe
//   write_enable_n             active-low write strobe (wins over a read)
//   A0                         register address bit
//   data_bus_in[7:0]           CPU write data
//   data_bus_out[7:0]          read data, or the vector during the 2nd INTA pulse
//   IRRperipheralInterrupts    request lines IR7..IR0, active high
//   eoi                        non-specific end-of-interrupt pulse (rising edge)
//   INTA                       interrupt acknowledge, active low
//   INT                        registered interrupt request to the CPU
//
// Handshake: writes are level-sensitive; every clk edge that sees
// chip_select_n=0 and write_enable_n=0 performs one write. INTA falling edges
// are found by comparing against the previous sample; the first edge (only
// while INT=1) moves the winning IRR bit into ISR, the second edge completes the
// sequence and the vector is driven for as long as INTA stays low.
//
// Build option: PIC_AUTO_EOI_EN -- when defined, the ISR bit is cleared as the
// second INTA falling edge completes the sequence and explicit EOIs are ignored.
module control_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       A0,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out,
  input  logic [7:0] IRRperipheralInterrupts,
  input  logic       eoi,
  input  logic       INTA,
  output logic       INT
);

  typedef enum logic [1:0] {AWAIT_ICW1, AWAIT_ICW2, READY} init_state_t;
  typedef enum logic [1:0] {INTA_IDLE, INTA_ACK1, INTA_GAP, INTA_VEC} inta_state_t;

  init_state_t init_state, init_next;
  inta_state_t inta_state, inta_next;

  logic [7:0] irr, isr, imr;
  logic [7:0] irr_next, isr_next;
  logic [4:0] base;
  logic [2:0] level_q;
  logic       ltim, read_isr, int_q;
  logic [7:0] ir_prev;
  logic       inta_prev, eoi_prev;

  logic       wr_strobe, rd_strobe;
  logic       icw1_wr, icw2_wr, ocw1_wr, ocw2_wr, ocw3_wr;
  logic       ready, inta_fall, ack, complete, vec_active;
  logic [7:0] eligible, ack_mask, irr_set, isr_clr;

  // Bits strictly higher in priority than the highest in-service level.
  function automatic logic [7:0] prio_mask(input logic [7:0] s);
    logic       blk;
    logic [7:0] m;
    blk = 1'b0;
    m   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      blk  = blk | s[i];
      m[i] = ~blk;
    end
    return m;
  endfunction

  // Index of the single set bit of a one-hot (or zero) value.
  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign wr_strobe = !chip_select_n && !write_enable_n;
  assign rd_strobe = !chip_select_n && !read_enable_n && write_enable_n;
  assign icw1_wr   = wr_strobe && !A0 && data_bus_in[4];
  assign ocw2_wr   = wr_strobe && !A0 && (data_bus_in[4:3] == 2'b00);
  assign ocw3_wr   = wr_strobe && !A0 && (data_bus_in[4:3] == 2'b01);
  assign icw2_wr   = wr_strobe && A0 && (init_state == AWAIT_ICW2);
  assign ocw1_wr   = wr_strobe && A0 && (init_state == READY);

  assign ready     = (init_state == READY);
  assign inta_fall = inta_prev && !INTA;
  assign eligible  = irr & ~imr & prio_mask(isr);
  assign vec_active = ((inta_state == INTA_GAP) || (inta_state == INTA_VEC)) && !INTA;

  // Init and INTA sequencers.
  always_comb begin
    init_next = init_state;
    inta_next = inta_state;
    ack       = 1'b0;
    complete  = 1'b0;
    if (icw1_wr)      init_next = AWAIT_ICW2;
    else if (icw2_wr) init_next = READY;
    case (inta_state)
      INTA_IDLE: if (inta_fall && int_q && (eligible != 8'h00)) begin
        inta_next = INTA_ACK1;
        ack       = 1'b1;
      end
      INTA_ACK1: if (INTA) inta_next = INTA_GAP;
      INTA_GAP:  if (inta_fall) begin
        inta_next = INTA_VEC;
        complete  = 1'b1;
      end
      INTA_VEC:  if (INTA) inta_next = INTA_IDLE;
      default:   inta_next = INTA_IDLE;
    endcase
    // A new ICW1 abandons any acknowledge in flight.
    if (icw1_wr) begin
      inta_next = INTA_IDLE;
      ack       = 1'b0;
      complete  = 1'b0;
    end
  end

  // Register datapath. Acknowledge beats a same-cycle request edge; EOI acts on
  // the ISR value before this cycle's acknowledge is merged in.
  always_comb begin
    ack_mask = ack ? (eligible & (~eligible + 8'd1)) : 8'h00;
    irr_set  = 8'h00;
    if (ready) begin
      irr_set = IRRperipheralInterrupts & ~ir_prev;
      if (ltim) irr_set = irr_set | (IRRperipheralInterrupts & ~irr & ~isr);
    end
    irr_next = (irr | irr_set) & ~ack_mask;
`ifdef PIC_AUTO_EOI_EN
    isr_clr = complete ? (8'h01 << level_q) : 8'h00;
`else
    isr_clr = ((eoi && !eoi_prev) || (ocw2_wr && data_bus_in[5]))
              ? (isr & (~isr + 8'd1)) : 8'h00;
`endif
    isr_next = (isr & ~isr_clr) | ack_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_state <= AWAIT_ICW1;
      inta_state <= INTA_IDLE;
      irr        <= 8'h00;
      isr        <= 8'h00;
      imr        <= 8'h00;
      base       <= 5'd0;
      level_q    <= 3'd0;
      ltim       <= 1'b0;
      read_isr   <= 1'b0;
      int_q      <= 1'b0;
      ir_prev    <= 8'h00;
      inta_prev  <= 1'b1;
      eoi_prev   <= 1'b0;
    end else begin
      init_state <= init_next;
      inta_state <= inta_next;
      ir_prev    <= IRRperipheralInterrupts;
      inta_prev  <= INTA;
      eoi_prev   <= eoi;
      if (icw1_wr) begin
        ltim     <= data_bus_in[3];
        irr      <= 8'h00;
        isr      <= 8'h00;
        imr      <= 8'h00;
        read_isr <= 1'b0;
      end else begin
        irr <= irr_next;
        isr <= isr_next;
        if (ocw1_wr) imr <= data_bus_in;
        if (icw2_wr) base <= data_bus_in[7:3];
        if (ocw3_wr && data_bus_in[1]) read_isr <= data_bus_in[0];
      end
      if (ack) level_q <= encode(ack_mask);
      // INT drops on the acknowledging edge and otherwise follows the
      // registers as they stood this cycle.
      int_q <= ready && !icw1_wr && !ack && (eligible != 8'h00);
    end
  end

  assign INT = int_q;

  always_comb begin
    data_bus_out = 8'h00;
    if (vec_active)     data_bus_out = {base, level_q};
    else if (rd_strobe) data_bus_out = A0 ? imr : (read_isr ? isr : irr);
  end

endmodule

// File: tb/tb_control_logic.sv
module tb_control_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       chip_select_n = 1'b1;
  logic       read_enable_n = 1'b1;
  logic       write_enable_n = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] data_bus_in = 8'h00;
  logic [7:0] data_bus_out;
  logic [7:0] IRRperipheralInterrupts = 8'h00;
  logic       eoi = 1'b0;
  logic       INTA = 1'b1;
  logic       INT;

  int n_checks = 0;
  int n_fail   = 0;

  control_logic dut (
    .clk                     (clk),
    .reset                   (reset),
    .chip_select_n           (chip_select_n),
    .read_enable_n           (read_enable_n),
    .write_enable_n          (write_enable_n),
    .A0                      (A0),
    .data_bus_in             (data_bus_in),
    .data_bus_out            (data_bus_out),
    .IRRperipheralInterrupts (IRRperipheralInterrupts),
    .eoi                     (eoi),
    .INTA                    (INTA),
    .INT                     (INT)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic write_reg(input logic a0, input logic [7:0] d);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    A0             = a0;
    data_bus_in    = d;
    tick(1);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    data_bus_in    = 8'h00;
  endtask

  task automatic read_check(input string tag, input logic a0, input logic [7:0] exp);
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    A0            = a0;
    #1;
    check(tag, data_bus_out, exp);
    tick(1);
    chip_select_n = 1'b1;
    read_enable_n = 1'b1;
  endtask

  task automatic ir_pulse(input logic [7:0] lines, input int cycles);
    IRRperipheralInterrupts = lines;
    tick(cycles);
    IRRperipheralInterrupts = 8'h00;
    tick(2);
  endtask

  task automatic eoi_pulse();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(2);
  endtask

  // One INTA low pulse; optionally checks the vector across the pulse.
  task automatic inta_pulse(input logic chk, input logic [7:0] exp_vec);
    INTA = 1'b0;
    #1;
    if (chk) check("vector_early", data_bus_out, exp_vec);
    tick(1);
    if (chk) check("vector_held", data_bus_out, exp_vec);
    tick(1);
    INTA = 1'b1;
    tick(2);
  endtask

  task automatic acknowledge(input logic [7:0] exp_vec);
    inta_pulse(1'b0, 8'h00);
    inta_pulse(1'b1, exp_vec);
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("reset_int", {7'd0, INT}, 8'h00);
    check("reset_bus_idle", data_bus_out, 8'h00);
    read_check("reset_irr", 1'b0, 8'h00);
    read_check("reset_imr", 1'b1, 8'h00);

    // Requests before initialisation are ignored
    ir_pulse(8'h02, 1);
    check("preinit_int", {7'd0, INT}, 8'h00);
    read_check("preinit_irr", 1'b0, 8'h00);

    // ICW1 level mode, base 0x00, no masks
    write_reg(1'b0, 8'h18);
    write_reg(1'b1, 8'h00);
    write_reg(1'b1, 8'h00);
    ir_pulse(8'h81, 1);
    check("int_after_ir", {7'd0, INT}, 8'h01);
    read_check("irr_81", 1'b0, 8'h81);

    // First ack takes IR0, vector 0x00; third pulse ignored
    acknowledge(8'h00);
    inta_pulse(1'b0, 8'h00);
    check("int_blocked_by_isr0", {7'd0, INT}, 8'h00);
    write_reg(1'b0, 8'h0A);
    read_check("irr_80", 1'b0, 8'h80);
    write_reg(1'b0, 8'h0B);
    read_check("isr_01", 1'b0, 8'h01);

    // EOI frees IR7
    eoi_pulse();
    read_check("isr_after_eoi", 1'b0, 8'h00);
    check("int_ir7_pending", {7'd0, INT}, 8'h01);
    acknowledge(8'h07);
    read_check("isr_80", 1'b0, 8'h80);
    check("int_after_ir7_ack", {7'd0, INT}, 8'h00);

    // Nesting: IR0 preempts IR7 in service
    ir_pulse(8'h01, 1);
    check("int_nested", {7'd0, INT}, 8'h01);
    acknowledge(8'h00);
    read_check("isr_81", 1'b0, 8'h81);
    eoi_pulse();
    read_check("isr_eoi_lowest", 1'b0, 8'h80);

    // Masking a pending request drops INT
    ir_pulse(8'h04, 1);
    check("int_ir2", {7'd0, INT}, 8'h01);
    write_reg(1'b1, 8'hFF);
    tick(2);
    check("int_masked", {7'd0, INT}, 8'h00);
    read_check("imr_ff", 1'b1, 8'hFF);

    // OCW2 non-specific EOI
    write_reg(1'b0, 8'h20);
    read_check("isr_ocw2_eoi", 1'b0, 8'h00);

    // Re-init: edge mode, base 0x48; ICW1 clears IMR and read-select
    write_reg(1'b0, 8'h10);
    write_reg(1'b1, 8'h48);
    read_check("imr_cleared", 1'b1, 8'h00);
    ir_pulse(8'h08, 4);
    read_check("irr_edge_once", 1'b0, 8'h08);
    check("int_ir3", {7'd0, INT}, 8'h01);
    acknowledge(8'h4B);
    write_reg(1'b0, 8'h0B);
    read_check("isr_08", 1'b0, 8'h08);
    ir_pulse(8'h20, 1);
    check("int_lower_blocked", {7'd0, INT}, 8'h00);

    // Reset in the middle of an acknowledge
    ir_pulse(8'h02, 1);
    check("int_ir1", {7'd0, INT}, 8'h01);
    INTA = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    INTA = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("rst_int", {7'd0, INT}, 8'h00);
    check("rst_bus", data_bus_out, 8'h00);
    read_check("rst_irr", 1'b0, 8'h00);
    read_check("rst_imr", 1'b1, 8'h00);
    write_reg(1'b0, 8'h0B);
    read_check("rst_isr", 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_logic.md
# control_logic

Core control block of the 8259A-compatible programmable interrupt controller. Decodes CPU register writes (ICW1, ICW2, OCW1-OCW3) and reads, holds the IRR/ISR/IMR registers, resolves fixed priority over eight peripheral request lines, and drives INT plus the INTA vector handshake toward an 8086-style CPU. All state is clocked on a single system clock.

## Interface
No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- chip_select_n  in  1  active-low chip select
- read_enable_n  in  1  active-low read strobe
- write_enable_n  in  1  active-low write strobe
- A0  in  1  register address bit
- data_bus_in  in  8  CPU write data
- data_bus_out  out  8  read data / interrupt vector
- IRRperipheralInterrupts  in  8  request lines IR7..IR0, active high
- eoi  in  1  non-specific end-of-interrupt pulse, active high
- INTA  in  1  interrupt acknowledge, active low
- INT  out  1  interrupt request to CPU, active high

## Operation
- Write: each clk edge with chip_select_n=0 and write_enable_n=0 processes one write (level-sensitive; held strobes repeat the write). Write takes priority over a simultaneous read.
- A0=0, D4=1: ICW1. Latch LTIM=D3; clear IMR, ISR, IRR, read-select (IRR); next A0=1 write is ICW2. D1/D0 ignored (single, no ICW3/ICW4).
- A0=1 after ICW1: ICW2, latch vector base D7:D3; init complete. Later A0=1 writes: OCW1, IMR=data.
- A0=0, D4:3=00: OCW2; D5=1 performs non-specific EOI. A0=0, D4:3=01: OCW3; D1:0=10 selects IRR read, 11 selects ISR read, else unchanged.
- Before init completes, requests are ignored and INT stays 0.
- IRR: bit sets on rising edge of IRn (sampled vs previous cycle); in LTIM=1 mode also sets whenever IRn is high and bit n of IRR and ISR are clear. Bit clears only when acknowledged.
- Priority: fixed, IR0 highest. INT=1 when some bit of IRR&~IMR has higher priority than the highest set ISR bit (nesting allowed).
- INTA: falling edges detected against previous sample. First falling edge (only counted when INT=1): highest eligible IRR bit moves to ISR, INT drops. Second falling edge: sequence completes; while INTA=0 in that pulse data_bus_out = {base[7:3], level[2:0]}. Falling edges with INT=0 and no sequence active are ignored.
- EOI (eoi rising edge or OCW2 EOI): clear highest-priority set ISR bit; no-op if ISR=0.
- Read (chip_select_n=0, read_enable_n=0, no vector active): A0=0 returns IRR or ISR per read-select; A0=1 returns IMR. Otherwise data_bus_out=0x00.

## Timing
- Reset: IRR, ISR, IMR, base, LTIM=0, read-select=IRR, init state=await ICW1, INTA sequence idle, INT=0, data_bus_out=0x00.
- Register writes, IRR set, ISR transfer, EOI take effect on the clk edge where sampled; INT is registered, valid one cycle after the causing state change.
- data_bus_out is combinational from current registers and inputs.
- ICW1 mid-INTA-sequence aborts the sequence.
- Simultaneous IR edge and acknowledge of same bit: acknowledge wins, new edge lost. EOI and ISR set same cycle: EOI applies to pre-update ISR, then set.

## Configuration
- PIC_AUTO_EOI_EN defined: ISR bit cleared automatically on the cycle the second INTA falling edge completes the sequence; eoi/OCW2 EOI become no-ops.
- Undefined: ISR bit held until explicit EOI.

## Test plan
- ICW1=0x18, ICW2=0x00, OCW1=0x00; IR=0x81 one slot -> IRR=0x81, INT=1 next cycle.
- Three INTA low pulses -> after first ISR=0x01, IRR=0x80; vector 0x00 on second pulse; INT reasserts? no (IR7 blocked by ISR bit0) -> INT=0.
- OCW3 0x0A then read -> data_bus_out=IRR=0x80; OCW3 0x0B -> 0x01.
- eoi pulse -> ISR=0x00, INT=1 (IR7 pending); acknowledge -> ISR=0x80, vector 0x07.
- IR0 while ISR=0x80 -> INT=1; acknowledge -> ISR=0x81; eoi -> ISR=0x80.
- OCW1=0xFF with pending IRR -> INT=0; reset mid-sequence -> all registers 0, INT=0.
